button_event_gen: RTL

//  Consumes one debounced button level and turns it into discrete events:

---
 rtl/button_event_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/long/repeat strobes,
// latched into a one-entry event register with valid/ack and sticky overrun.
module button_event_gen #(
  parameter int unsigned HOLD_CYCLES   = 19_000_000,
  parameter int unsigned REPEAT_CYCLES = 3_800_000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       db_in,
  input  logic       repeat_en,
  input  logic       event_ack,
  input  logic       overrun_clr,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic       event_valid,
  output logic [1:0] event_code,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             db_q;
  logic             rise, fall;
  logic             press_nxt, release_nxt, long_nxt, repeat_nxt;
  logic             strobe;
  logic [1:0]       strobe_code;

  assign rise = db_in & ~db_q;
  assign fall = ~db_in & db_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      db_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      db_q  <= db_in;
    end
  end

  // Fall is tested before the threshold so a release always beats long/repeat.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else if (cnt == HOLD_LAST) begin
            state_nxt = LONG;
            cnt_nxt   = '0;
            long_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        LONG: begin
          if (fall) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else if (!repeat_en) begin
            cnt_nxt = '0;
          end else if (cnt == REPEAT_LAST) begin
            cnt_nxt    = '0;
            repeat_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    held        = (state == PRESSED) || (state == LONG);
    strobe      = press_pulse | release_pulse | long_pulse | repeat_pulse;
    strobe_code = 2'b00;
    if (repeat_pulse)       strobe_code = 2'b11;
    else if (long_pulse)    strobe_code = 2'b10;
    else if (release_pulse) strobe_code = 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

  // The event register captures a strobe during the cycle it is visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_valid <= 1'b0;
      event_code  <= 2'b00;
      overrun     <= 1'b0;
    end else begin
      if (strobe) begin
        if (!event_valid || event_ack) begin
          event_valid <= 1'b1;
          event_code  <= strobe_code;
        end
      end else if (event_ack) begin
        event_valid <= 1'b0;
      end
      if (strobe && event_valid && !event_ack) overrun <= 1'b1;
      else if (overrun_clr)                    overrun <= 1'b0;
    end
  end

endmodule
